// File: rtl/hitbox_pkg.sv
// Shared constants, FSM state encoding and width helper for the hitbox detector.
package hitbox_pkg;

  localparam int unsigned COORD_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    INVULN = 2'd2
  } hitbox_state_e;

  // ceil(log2(v)) with a floor of 1 so single-value ranges still get a bit
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/hitbox_detector_if.sv
// Game-side bus of the hitbox detector: cursor/obstacle inputs and hit outputs.
interface hitbox_detector_if import hitbox_pkg::*; #(
  parameter int unsigned N_OBST  = 4,
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned CNT_W   = 8
);

  localparam int unsigned IDX_W = clog2_min1(N_OBST);

  logic                      enable_in;
  logic                      clear_in;
  logic [COORD_W-1:0]        mouse_x_in;
  logic [COORD_W-1:0]        mouse_y_in;
  logic [N_OBST*COORD_W-1:0] obstacle_x_in;
  logic [N_OBST*COORD_W-1:0] obstacle_y_in;
  logic [N_OBST-1:0]         obstacle_valid_in;
  logic                      damage_out;
  logic                      invuln_out;
  logic [IDX_W-1:0]          hit_idx_out;
  logic [CNT_W-1:0]          hit_count_out;

  modport master (
    output enable_in, clear_in, mouse_x_in, mouse_y_in,
           obstacle_x_in, obstacle_y_in, obstacle_valid_in,
    input  damage_out, invuln_out, hit_idx_out, hit_count_out
  );

  modport slave (
    input  enable_in, clear_in, mouse_x_in, mouse_y_in,
           obstacle_x_in, obstacle_y_in, obstacle_valid_in,
    output damage_out, invuln_out, hit_idx_out, hit_count_out
  );

endinterface

// File: rtl/hitbox_overlap.sv
// One obstacle channel: strict rectangle-overlap test, registered.
module hitbox_overlap #(
  parameter int unsigned COORD_W = 12,
  parameter int unsigned CUR_W   = 16,
  parameter int unsigned CUR_H   = 16,
  parameter int unsigned OBS_W   = 16,
  parameter int unsigned OBS_H   = 16
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [COORD_W-1:0] mx,
  input  logic [COORD_W-1:0] my,
  input  logic [COORD_W-1:0] ox,
  input  logic [COORD_W-1:0] oy,
  input  logic               valid,
  output logic               ovl_q
);

  localparam logic [COORD_W:0] CW = (COORD_W+1)'(CUR_W);
  localparam logic [COORD_W:0] CH = (COORD_W+1)'(CUR_H);
  localparam logic [COORD_W:0] OW = (COORD_W+1)'(OBS_W);
  localparam logic [COORD_W:0] OH = (COORD_W+1)'(OBS_H);

  // One extra bit keeps right/bottom edges near the screen limit from wrapping
  logic [COORD_W:0] mx_e, my_e, ox_e, oy_e;
  logic             ovl_d;

  assign mx_e = {1'b0, mx};
  assign my_e = {1'b0, my};
  assign ox_e = {1'b0, ox};
  assign oy_e = {1'b0, oy};

  // Strict inequalities: boxes that only share an edge do not collide
  always_comb begin
    ovl_d = valid
         && (mx_e < ox_e + OW) && (ox_e < mx_e + CW)
         && (my_e < oy_e + OH) && (oy_e < my_e + CH);
  end

  // Stage-1 register of the overlap flag
  always_ff @(posedge pclk) begin
    if (rst) ovl_q <= 1'b0;
    else     ovl_q <= ovl_d;
  end

endmodule

// File: rtl/hitbox_detector.sv
// Cursor-vs-obstacle hit detector with invulnerability window and hit counter.
module hitbox_detector import hitbox_pkg::*; #(
  parameter int unsigned N_OBST        = 4,
  parameter int unsigned COORD_W       = COORD_W_DEF,
  parameter int unsigned CUR_W         = 16,
  parameter int unsigned CUR_H         = 16,
  parameter int unsigned OBS_W         = 16,
  parameter int unsigned OBS_H         = 16,
  parameter int unsigned INVULN_CYCLES = 32500000,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              pclk,
  input  logic              rst,
  hitbox_detector_if.slave  bus
);

  localparam int unsigned IDX_W = clog2_min1(N_OBST);
  localparam int unsigned TMR_W = clog2_min1(INVULN_CYCLES + 1);
  // Zero-length window still spends one cycle in INVULN
  localparam logic [TMR_W-1:0] TMR_LAST =
    (INVULN_CYCLES == 0) ? '0 : TMR_W'(INVULN_CYCLES - 1);

  logic [N_OBST-1:0] ovl_q;
  logic [IDX_W-1:0]  first_idx;
  logic              found;

  hitbox_state_e     state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              dmg_q, dmg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit;

  for (genvar i = 0; i < N_OBST; i++) begin : g_ch
    hitbox_overlap #(
      .COORD_W (COORD_W),
      .CUR_W   (CUR_W),
      .CUR_H   (CUR_H),
      .OBS_W   (OBS_W),
      .OBS_H   (OBS_H)
    ) u_ovl (
      .pclk  (pclk),
      .rst   (rst),
      .mx    (bus.mouse_x_in),
      .my    (bus.mouse_y_in),
      .ox    (bus.obstacle_x_in[i*COORD_W +: COORD_W]),
      .oy    (bus.obstacle_y_in[i*COORD_W +: COORD_W]),
      .valid (bus.obstacle_valid_in[i]),
      .ovl_q (ovl_q[i])
    );
  end

  // Lowest-numbered overlapping channel wins
  always_comb begin
    first_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N_OBST; i++) begin
      if (ovl_q[i] && !found) begin
        first_idx = IDX_W'(i);
        found     = 1'b1;
      end
    end
  end

  // Next-state, window timer, hit capture and saturating hit counter
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    dmg_d   = 1'b0;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable_in) state_d = ARMED;
      end
      ARMED: begin
        if (|ovl_q) begin
          hit     = 1'b1;
          dmg_d   = 1'b1;
          idx_d   = first_idx;
          tmr_d   = '0;
          state_d = INVULN;
        end
      end
      INVULN: begin
        if (tmr_q == TMR_LAST) state_d = ARMED;
        else                   tmr_d   = tmr_q + TMR_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // Disable overrides whatever the state logic decided above
    if (!bus.enable_in) begin
      state_d = IDLE;
      tmr_d   = '0;
      dmg_d   = 1'b0;
      idx_d   = idx_q;
      hit     = 1'b0;
    end
    // A clear coinciding with a hit leaves exactly that one hit counted
    if (hit) begin
      if (bus.clear_in)   cnt_d = CNT_W'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (bus.clear_in) begin
      cnt_d = '0;
    end
  end

  // Stage-2 registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      dmg_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      dmg_q   <= dmg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.damage_out    = dmg_q;
  assign bus.invuln_out    = (state_q == INVULN);
  assign bus.hit_idx_out   = idx_q;
  assign bus.hit_count_out = cnt_q;

endmodule

// File: tb/tb_hitbox_detector.sv
// Directed bench for hitbox_detector: default config, short window with 2-bit
// counter, and zero-length window, all driven by the same stimulus.
module tb_hitbox_detector;

  logic        pclk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear;
  logic [11:0] mx, my;
  logic [47:0] ox_v, oy_v;
  logic [3:0]  valid;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int p [5];
  int np;
  int inv_n;
  int cb2;

  always #5 pclk = ~pclk;

  hitbox_detector_if #(.N_OBST(4), .COORD_W(12), .CNT_W(8)) if_a ();
  hitbox_detector_if #(.N_OBST(4), .COORD_W(12), .CNT_W(2)) if_b ();
  hitbox_detector_if #(.N_OBST(4), .COORD_W(12), .CNT_W(8)) if_c ();

  assign if_a.enable_in = enable;  assign if_b.enable_in = enable;  assign if_c.enable_in = enable;
  assign if_a.clear_in  = clear;   assign if_b.clear_in  = clear;   assign if_c.clear_in  = clear;
  assign if_a.mouse_x_in = mx;     assign if_b.mouse_x_in = mx;     assign if_c.mouse_x_in = mx;
  assign if_a.mouse_y_in = my;     assign if_b.mouse_y_in = my;     assign if_c.mouse_y_in = my;
  assign if_a.obstacle_x_in = ox_v; assign if_b.obstacle_x_in = ox_v; assign if_c.obstacle_x_in = ox_v;
  assign if_a.obstacle_y_in = oy_v; assign if_b.obstacle_y_in = oy_v; assign if_c.obstacle_y_in = oy_v;
  assign if_a.obstacle_valid_in = valid;
  assign if_b.obstacle_valid_in = valid;
  assign if_c.obstacle_valid_in = valid;

  hitbox_detector dut_a (.pclk(pclk), .rst(rst), .bus(if_a));

  hitbox_detector #(.INVULN_CYCLES(10), .CNT_W(2)) dut_b (.pclk(pclk), .rst(rst), .bus(if_b));

  hitbox_detector #(.INVULN_CYCLES(0)) dut_c (.pclk(pclk), .rst(rst), .bus(if_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_obs(input int unsigned ch, input int unsigned x, input int unsigned y,
                         input logic v);
    ox_v[ch*12 +: 12] = 12'(x);
    oy_v[ch*12 +: 12] = 12'(y);
    valid[ch]         = v;
  endtask

  // Drop enable for one cycle to force IDLE, then re-arm
  task automatic rearm();
    valid  = '0;
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0;
    mx = '0; my = '0; ox_v = '0; oy_v = '0; valid = '0;
    tick(); tick();
    check("rst_dmg_a", 32'(if_a.damage_out), 0);
    check("rst_inv_a", 32'(if_a.invuln_out), 0);
    check("rst_idx_a", 32'(if_a.hit_idx_out), 0);
    check("rst_cnt_a", 32'(if_a.hit_count_out), 0);
    check("rst_cnt_b", 32'(if_b.hit_count_out), 0);
    rst = 1'b0;

    // Basic hit: pulse two cycles after presentation
    mx = 100; my = 100; set_obs(0, 110, 110, 1'b1); enable = 1'b1;
    tick();
    check("lat1_dmg_a", 32'(if_a.damage_out), 0);
    tick();
    check("hit_dmg_a", 32'(if_a.damage_out), 1);
    check("hit_idx_a", 32'(if_a.hit_idx_out), 0);
    check("hit_cnt_a", 32'(if_a.hit_count_out), 1);
    check("hit_inv_a", 32'(if_a.invuln_out), 1);
    check("hit_dmg_c", 32'(if_c.damage_out), 1);
    tick();
    check("post_dmg_a", 32'(if_a.damage_out), 0);
    check("zwin_dmg_c0", 32'(if_c.damage_out), 0);
    tick();
    check("zwin_dmg_c1", 32'(if_c.damage_out), 1);
    check("zwin_cnt_c", 32'(if_c.hit_count_out), 2);

    // Touching edge never collides; one pixel closer does
    rearm();
    set_obs(1, 116, 100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("touch_dmg_a", 32'(if_a.damage_out), 0);
    end
    check("touch_cnt_a", 32'(if_a.hit_count_out), 1);
    set_obs(1, 115, 100, 1'b1);
    tick(); tick();
    check("edge1_dmg_a", 32'(if_a.damage_out), 1);
    check("edge1_idx_a", 32'(if_a.hit_idx_out), 1);
    check("edge1_cnt_a", 32'(if_a.hit_count_out), 2);

    // Channels 1 and 3 together: one pulse, lowest index
    rearm();
    set_obs(1, 110, 100, 1'b1);
    set_obs(3, 90, 90, 1'b1);
    tick(); tick();
    check("multi_dmg_a", 32'(if_a.damage_out), 1);
    check("multi_idx_a", 32'(if_a.hit_idx_out), 1);
    check("multi_cnt_a", 32'(if_a.hit_count_out), 3);
    tick();
    check("multi_once_a", 32'(if_a.damage_out), 0);

    // Clear pulse
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_cnt_a", 32'(if_a.hit_count_out), 0);
    check("clr_cnt_b", 32'(if_b.hit_count_out), 0);

    // Held overlap on the 10-cycle window: pulse spacing, window length, saturation
    rearm();
    set_obs(0, 110, 110, 1'b1);
    np = 0; inv_n = 0; cb2 = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (if_b.damage_out) begin
        if (np < 5) p[np] = i;
        np++;
        if (np == 2) cb2 = int'(if_b.hit_count_out);
      end
      if (np == 1 && if_b.invuln_out) inv_n++;
    end
    check("win_npulse", 32'(np), 5);
    check("win_first", 32'(p[0]), 2);
    check("win_gap01", 32'(p[1] - p[0]), 11);
    check("win_gap12", 32'(p[2] - p[1]), 11);
    check("win_gap34", 32'(p[4] - p[3]), 11);
    check("win_inv_len", 32'(inv_n), 10);
    check("win_cnt2_b", 32'(cb2), 2);
    check("sat_cnt_b", 32'(if_b.hit_count_out), 3);
    check("long_inv_cnt_a", 32'(if_a.hit_count_out), 1);

    // Clear and hit in the same cycle
    rearm();
    set_obs(0, 110, 110, 1'b1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clrhit_dmg_b", 32'(if_b.damage_out), 1);
    check("clrhit_cnt_b", 32'(if_b.hit_count_out), 1);
    check("clrhit_cnt_a", 32'(if_a.hit_count_out), 1);

    // Far corner: no wrap-around, but a genuine edge overlap still hits
    rearm();
    mx = 4090; my = 4090; set_obs(0, 5, 5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wrap_dmg_a", 32'(if_a.damage_out), 0);
    end
    set_obs(0, 4080, 4080, 1'b1);
    tick(); tick();
    check("corner_dmg_a", 32'(if_a.damage_out), 1);
    check("corner_cnt_a", 32'(if_a.hit_count_out), 2);
    check("corner_cnt_b", 32'(if_b.hit_count_out), 2);

    // Reset in the middle of the window
    rearm();
    mx = 100; my = 100; set_obs(2, 100, 100, 1'b1);
    tick(); tick();
    check("pre_rst_dmg_b", 32'(if_b.damage_out), 1);
    check("pre_rst_idx_b", 32'(if_b.hit_idx_out), 2);
    repeat (5) tick();
    check("pre_rst_inv_b", 32'(if_b.invuln_out), 1);
    rst = 1'b1;
    tick();
    check("mid_rst_dmg_b", 32'(if_b.damage_out), 0);
    check("mid_rst_inv_b", 32'(if_b.invuln_out), 0);
    check("mid_rst_idx_b", 32'(if_b.hit_idx_out), 0);
    check("mid_rst_cnt_b", 32'(if_b.hit_count_out), 0);
    rst = 1'b0;
    tick();
    check("after_rst_dmg_b", 32'(if_b.damage_out), 0);
    tick();
    check("rehit_dmg_b", 32'(if_b.damage_out), 1);
    check("rehit_cnt_b", 32'(if_b.hit_count_out), 1);
    check("rehit_idx_b", 32'(if_b.hit_idx_out), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hitbox_detector.md
HITBOX_DETECTOR -- requirements
Module: hitbox_detector

Interface
REQ-001 The block SHALL have parameter N_OBST, default 4, meaning the number of obstacle channels (1..16).
REQ-002 The block SHALL have parameter COORD_W, default 12, meaning the coordinate width in bits.
REQ-003 The block SHALL have parameters CUR_W and CUR_H, default 16 each, meaning the cursor hitbox width and height in pixels.
REQ-004 The block SHALL have parameters OBS_W and OBS_H, default 16 each, meaning the obstacle hitbox width and height in pixels.
REQ-005 The block SHALL have parameter INVULN_CYCLES, default 32500000, meaning the invulnerability length in pclk cycles (0.5 s at 65 MHz).
REQ-006 The block SHALL have parameter CNT_W, default 8, meaning the width of the hit counter.
REQ-007 pclk  in  1  pixel clock; all logic is on the rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 enable_in  in  1  game active; when low, detection is suspended.
REQ-010 clear_in  in  1  one-cycle pulse that zeroes hit_count_out.
REQ-011 mouse_x_in, mouse_y_in  in  COORD_W each  top-left corner of the cursor hitbox.
REQ-012 obstacle_x_in, obstacle_y_in  in  N_OBST*COORD_W each  packed top-left corners; channel i occupies bits [i*COORD_W +: COORD_W].
REQ-013 obstacle_valid_in  in  N_OBST  per-channel enable; an invalid channel never hits.
REQ-014 damage_out  out  1  one-cycle pulse per accepted hit.
REQ-015 invuln_out  out  1  high while the invulnerability window runs.
REQ-016 hit_idx_out  out  clog2(N_OBST) (minimum 1)  channel index of the last accepted hit.
REQ-017 hit_count_out  out  CNT_W  number of accepted hits, saturating.

Function
REQ-018 Channel i SHALL overlap when all of the following hold: mx < ox+OBS_W, ox < mx+CUR_W, my < oy+OBS_H, oy < my+CUR_H, and valid[i] is high.
REQ-019 All sums SHALL be computed at COORD_W+1 bits so that edges near 2^COORD_W-1 do not wrap.
REQ-020 Touching edges SHALL not overlap (strict inequality).
REQ-021 Stage 1 SHALL register the per-channel overlap vector; stage 2 SHALL run the FSM. damage_out therefore rises 2 cycles after the overlapping inputs are presented.
REQ-022 The FSM SHALL have three states: IDLE, ARMED and INVULN.
REQ-023 IDLE->ARMED SHALL occur when enable_in=1. Any state SHALL go to IDLE when enable_in=0; this clears the counter and suppresses damage_out.
REQ-024 In ARMED, if the registered overlap vector is non-zero, the block SHALL:
- pulse damage_out for 1 cycle;
- load hit_idx_out with the lowest set index;
- increment hit_count_out;
- load the counter with 0 and go to INVULN.
REQ-025 Simultaneous overlaps on several channels SHALL produce one pulse, one increment, and the lowest index.
REQ-026 In INVULN, invuln_out SHALL be 1, overlaps SHALL be ignored, and the counter SHALL increment each cycle. When counter = INVULN_CYCLES-1 the FSM SHALL go to ARMED (window length exactly INVULN_CYCLES cycles).
REQ-027 With INVULN_CYCLES=0, INVULN SHALL last 1 cycle.
REQ-028 An overlap persisting past the end of INVULN SHALL produce the next hit in the first ARMED cycle that sees it.
REQ-029 hit_count_out SHALL saturate at 2^CNT_W-1.
REQ-030 If clear_in and a hit occur in the same cycle, hit_count_out SHALL become 1.
REQ-031 The counter width SHALL be clog2(INVULN_CYCLES+1), minimum 1.

Reset
REQ-032 On rst=1 the FSM SHALL go to IDLE, and the counter, overlap registers, damage_out, invuln_out, hit_idx_out and hit_count_out SHALL all be 0.
REQ-033 rst asserted mid-INVULN SHALL abort the window immediately, and no pulse SHALL be produced on the cycle after reset.

Structure
REQ-034 Package hitbox_pkg SHALL hold the FSM state encoding (IDLE=0, ARMED=1, INVULN=2, 2 bits) and the default COORD_W constant.
REQ-035 Sub-module hitbox_overlap SHALL implement one channel's registered comparison (REQ-018 to REQ-020) and SHALL be instantiated N_OBST times by generate.

Verification
REQ-036 Defaults, enable=1, mouse=(100,100), obstacle0=(110,110) valid -> damage_out pulse 2 cycles later, hit_idx=0, hit_count=1.
REQ-037 mouse=(100,100), obstacle1=(116,100) (touching edge) -> no damage_out.
REQ-038 INVULN_CYCLES=10, overlap held continuously -> pulses exactly 11 cycles apart, invuln_out high for 10 cycles after each pulse.
REQ-039 Channels 1 and 3 overlapping on the same cycle -> one pulse, hit_idx=1, hit_count increments by 1.
REQ-040 mouse=(4090,4090), obstacle=(5,5) -> no hit (no wrap); CNT_W=2 with 5 separated hits -> hit_count=3.
REQ-041 rst during INVULN (counter=5) -> all outputs 0 next cycle; a new overlap with enable=1 hits again 2 cycles after being presented.
